fakeram7_sp_arb2: RTL

- Two-requester arbiter and sequencer for one single-port fakeram7 SRAM macro (default 4096x32).
- Accepts independent valid/ready read/write requests from ports 0 and 1, and grants at most one per cycle using round-robin.
- Drives the macro's ce/we/addr/wd/w_mask pins and routes the 1-cycle-latency read data back to the originating requester.
- Sits between two client engines and the hard macro; the macro's ports connect directly to the mem_* ports.

---
 rtl/fakeram7_arb_pkg.sv | 18 +
 rtl/fakeram7_rr2_pick.sv | 32 +++
 rtl/fakeram7_sp_arb2.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/fakeram7_arb_pkg.sv
// -----------------------------------------------------------------------------
// fakeram7_arb_pkg
// Shared definitions for the two-port fakeram7 arbiter:
//   - NREQ, P0, P1 : requester count and port index constants
//   - arb_state_t  : init-sweep FSM states (ST_INIT, ST_RUN)
// -----------------------------------------------------------------------------
package fakeram7_arb_pkg;

   localparam int   NREQ = 2;
   localparam logic P0   = 1'b0;
   localparam logic P1   = 1'b1;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } arb_state_t;

endpackage : fakeram7_arb_pkg

// File: rtl/fakeram7_rr2_pick.sv
// -----------------------------------------------------------------------------
// fakeram7_rr2_pick
// Purely combinational two-way round-robin picker.
// Ports:
//   req_valid  in  [1:0]  per-port request valid
//   last_grant in  1      index of the most recently granted port
//   grant      out [1:0]  one-hot grant, zero when nothing is valid
//   grant_idx  out 1      index of the picked port (P0 when nothing is valid)
// -----------------------------------------------------------------------------
module fakeram7_rr2_pick
   import fakeram7_arb_pkg::*;
(
   input  logic [NREQ-1:0] req_valid,
   input  logic            last_grant,
   output logic [NREQ-1:0] grant,
   output logic            grant_idx
);

   always_comb begin
      // NOTE: every output gets a default first so no path can infer a latch.
      grant     = '0;
      grant_idx = P0;
      if (req_valid[P0] && req_valid[P1]) begin
         // On conflict the port that did not win last time goes next.
         grant_idx = (last_grant == P1) ? P0 : P1;
      end else if (req_valid[P1]) begin
         grant_idx = P1;
      end
      grant[grant_idx] = |req_valid;
   end

endmodule : fakeram7_rr2_pick

// File: rtl/fakeram7_sp_arb2.sv
// -----------------------------------------------------------------------------
// fakeram7_sp_arb2
// Two-requester round-robin arbiter/sequencer in front of one single-port
// fakeram7 SRAM macro (default 4096x32, 1-cycle read latency).
//
// Optional feature: define FAKERAM7_SP_ARB2_INIT_EN to zero-fill the whole
// macro after every reset (init_busy high for WORD_DEPTH cycles).
//
// Ports:
//   clk, rst                  clock shared with the macro; sync active-high reset
//   req_valid/ready/we  [1:0] per-port handshake and write enable
//   req_addr  [2*ADDR_WIDTH]  port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_wdata/req_wmask [2*BITS] port i at [i*BITS +: BITS]
//   resp_valid [1:0]          one-cycle read-data pulse per port
//   resp_rdata [BITS]         shared read data, qualified by resp_valid
//   mem_ce/we/addr/wd/wmask   straight to the macro's input pins
//   mem_rd                    from the macro's rd_out
//   init_busy                 high while the zero-fill sweep runs
// -----------------------------------------------------------------------------
module fakeram7_sp_arb2
   import fakeram7_arb_pkg::*;
#(
   parameter int BITS       = 32,
   parameter int WORD_DEPTH = 4096,
   parameter int ADDR_WIDTH = 12
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [1:0]              req_valid,
   output logic [1:0]              req_ready,
   input  logic [1:0]              req_we,
   input  logic [2*ADDR_WIDTH-1:0] req_addr,
   input  logic [2*BITS-1:0]       req_wdata,
   input  logic [2*BITS-1:0]       req_wmask,
   output logic [1:0]              resp_valid,
   output logic [BITS-1:0]         resp_rdata,
   output logic                    mem_ce,
   output logic                    mem_we,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   output logic [BITS-1:0]         mem_wd,
   output logic [BITS-1:0]         mem_wmask,
   input  logic [BITS-1:0]         mem_rd,
   output logic                    init_busy
);

   if (ADDR_WIDTH != $clog2(WORD_DEPTH)) begin : g_bad_addr_width
      $error("ADDR_WIDTH must equal clog2(WORD_DEPTH)");
   end

   logic                  last_grant;
   logic [1:0]            pick_grant;
   logic                  pick_idx;
   logic                  run;
   logic                  gnt_any;
   logic                  rsp_pend;
   logic                  rsp_idx;
   logic [ADDR_WIDTH-1:0] addr_hold;

   logic                  sel_we;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [BITS-1:0]       sel_wd;
   logic [BITS-1:0]       sel_wmask;

   fakeram7_rr2_pick u_pick (
      .req_valid  (req_valid),
      .last_grant (last_grant),
      .grant      (pick_grant),
      .grant_idx  (pick_idx)
   );

`ifdef FAKERAM7_SP_ARB2_INIT_EN
   arb_state_t            state;
   logic [ADDR_WIDTH-1:0] init_addr;
   logic                  init_busy_q;

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (rst) begin
         state       <= ST_INIT;
         init_addr   <= '0;
         init_busy_q <= 1'b1;
      end else begin
         case (state)
            ST_INIT: begin
               init_addr <= init_addr + 1'b1;
               if (init_addr == ADDR_WIDTH'(WORD_DEPTH - 1)) begin
                  state       <= ST_RUN;
                  init_busy_q <= 1'b0;
               end
            end
            default: state <= ST_RUN;
         endcase
      end
   end

   assign run       = (state == ST_RUN);
   assign init_busy = init_busy_q;
`else
   assign run       = 1'b1;
   assign init_busy = 1'b0;
`endif

   // Grants are suppressed during reset and during the init sweep.
   assign req_ready = (run && !rst) ? pick_grant : 2'b00;
   assign gnt_any   = |req_ready;

   assign sel_we    = req_we[pick_idx];
   assign sel_addr  = pick_idx ? req_addr[ADDR_WIDTH +: ADDR_WIDTH] : req_addr[0 +: ADDR_WIDTH];
   assign sel_wd    = pick_idx ? req_wdata[BITS +: BITS] : req_wdata[0 +: BITS];
   assign sel_wmask = pick_idx ? req_wmask[BITS +: BITS] : req_wmask[0 +: BITS];

   always_comb begin
      mem_ce    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = addr_hold;  // idle address stays put so the macro never sees X
      mem_wd    = '0;
      mem_wmask = '0;
`ifdef FAKERAM7_SP_ARB2_INIT_EN
      if (!rst && !run) begin
         mem_ce    = 1'b1;
         mem_we    = 1'b1;
         mem_addr  = init_addr;
         mem_wmask = '1;
      end
`endif
      if (gnt_any) begin
         mem_ce    = 1'b1;
         mem_we    = sel_we;
         mem_addr  = sel_addr;
         mem_wd    = sel_wd;
         mem_wmask = sel_wmask;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= P1;
         rsp_pend   <= 1'b0;
         rsp_idx    <= P0;
         addr_hold  <= '0;
      end else begin
         if (gnt_any) begin
            last_grant <= pick_idx;
         end
         // Tag the read so its data, arriving next cycle, goes back to its owner.
         rsp_pend <= gnt_any && !sel_we;
         rsp_idx  <= pick_idx;
         if (mem_ce) begin
            addr_hold <= mem_addr;
         end
      end
   end

   assign resp_valid = rsp_pend ? (rsp_idx ? 2'b10 : 2'b01) : 2'b00;
   assign resp_rdata = mem_rd;

endmodule : fakeram7_sp_arb2
